// File: rtl/mac_pkg.sv
// mac_pkg: shared helpers for the mac_tree_acc dot-product engine.
//   log2n      : adder-tree depth for N lanes
//   wacc_of    : accumulator width that holds the worst-case burst sum
//   sat_clip   : reports whether a sign-extended value lies above/below a WO-bit signed range
//   MAC_LANE   : lane slice of a packed lane vector, lane k at [k*w +: w]

`ifndef MAC_LANE
`define MAC_LANE(vec, k, w) vec[(k)*(w) +: (w)]
`endif

package mac_pkg;

  // Width used for the saturation compare; WACC must not exceed it.
  localparam int CLIP_W = 64;

  function automatic int log2n(input int n);
    return $clog2(n);
  endfunction

  function automatic int wacc_of(input int wi, input int n, input int mb);
    return 2*wi + $clog2(n) + $clog2(mb) + 1;
  endfunction

  // Returns {over, under}: over = t above 2^(wo-1)-1, under = t below -2^(wo-1).
  function automatic logic [1:0] sat_clip(input logic signed [CLIP_W-1:0] t, input int wo);
    logic signed [CLIP_W-1:0] hi;
    logic signed [CLIP_W-1:0] lo;
    hi = (64'sd1 <<< (wo-1)) - 64'sd1;
    lo = -(64'sd1 <<< (wo-1));
    return {(t > hi), (t < lo)};
  endfunction

endpackage

// File: rtl/mac_adder_tree.sv
// mac_adder_tree: registered pairwise signed adder tree, built recursively.
// Each level adds adjacent lane pairs with one bit of growth and registers the result;
// the valid and 3-bit flag sideband ride along with the same delay (log2(N) cycles).
//   clk, rst : clock, synchronous active-high reset
//   vld_i    : beat valid entering the tree
//   flg_i    : per-beat sideband, delayed alongside the data
//   din      : N signed lanes of WIN bits, lane k at [k*WIN +: WIN]
//   sum_o    : signed sum of all lanes, WIN+log2(N) bits
//   vld_o    : delayed vld_i
//   flg_o    : delayed flg_i

module mac_adder_tree #(
  parameter int N   = 16,
  parameter int WIN = 16
)(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       vld_i,
  input  logic [2:0]                 flg_i,
  input  logic [N*WIN-1:0]           din,
  output logic [WIN+$clog2(N)-1:0]   sum_o,
  output logic                       vld_o,
  output logic [2:0]                 flg_o
);

  localparam int NH = N / 2;
  localparam int WL = WIN + 1;

  logic [NH*WL-1:0] lvl_d;
  logic [NH*WL-1:0] lvl_q;
  logic             vld_q;
  logic [2:0]       flg_q;

  always_comb begin
    lvl_d = '0;
    for (int k = 0; k < NH; k++) begin
      `MAC_LANE(lvl_d, k, WL) = {din[(2*k+1)*WIN-1], `MAC_LANE(din, 2*k, WIN)}
                              + {din[(2*k+2)*WIN-1], `MAC_LANE(din, 2*k+1, WIN)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lvl_q <= '0;
      vld_q <= 1'b0;
      flg_q <= '0;
    end else begin
      lvl_q <= lvl_d;
      vld_q <= vld_i;
      flg_q <= flg_i;
    end
  end

  generate
    if (NH == 1) begin : g_leaf
      assign sum_o = lvl_q;
      assign vld_o = vld_q;
      assign flg_o = flg_q;
    end else begin : g_next
      mac_adder_tree #(.N(NH), .WIN(WL)) u_next (
        .clk   (clk),
        .rst   (rst),
        .vld_i (vld_q),
        .flg_i (flg_q),
        .din   (lvl_q),
        .sum_o (sum_o),
        .vld_o (vld_o),
        .flg_o (flg_o)
      );
    end
  endgenerate

endmodule

// File: rtl/mac_tree_acc.sv
// mac_tree_acc: signed N-lane dot-product engine with multi-beat burst accumulation
// and shift/ReLU/saturation quantiser. Result appears LOG2N+4 cycles after the last beat.
//   clk, rst : clock, synchronous active-high reset
//   vld_i    : beat valid (no backpressure)
//   first_i  : beat opens a burst (restarts an open one)
//   last_i   : beat closes the burst
//   relu_i   : ReLU enable, taken from the last beat
//   win, din : N signed WI-bit weights / activations, lane k at [k*WI +: WI]
//   acc_o    : raw burst sum, WACC bits
//   q_o      : quantised result, WO bits
//   sat_o    : q_o was clipped
//   vld_o    : one-cycle pulse per completed burst

module mac_tree_acc
  import mac_pkg::*;
#(
  parameter int WI        = 8,
  parameter int N         = 16,
  parameter int MAX_BEATS = 64,
  parameter int WO        = 8,
  parameter int SHIFT     = 0,
  localparam int WACC     = wacc_of(WI, N, MAX_BEATS)
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              vld_i,
  input  logic              first_i,
  input  logic              last_i,
  input  logic              relu_i,
  input  logic [N*WI-1:0]   win,
  input  logic [N*WI-1:0]   din,
  output logic [WACC-1:0]   acc_o,
  output logic [WO-1:0]     q_o,
  output logic              sat_o,
  output logic              vld_o
);

  localparam int LOG2N = log2n(N);
  localparam int WP    = 2 * WI;
  localparam int WT    = WP + LOG2N;

  // S0: input register
  logic [N*WI-1:0] w_q, d_q;
  logic            vld0_q, first0_q, last0_q, relu0_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_q      <= '0;
      d_q      <= '0;
      vld0_q   <= 1'b0;
      first0_q <= 1'b0;
      last0_q  <= 1'b0;
      relu0_q  <= 1'b0;
    end else begin
      w_q      <= win;
      d_q      <= din;
      vld0_q   <= vld_i;
      first0_q <= first_i;
      last0_q  <= last_i;
      relu0_q  <= relu_i;
    end
  end

  // S1: products. Operands are sign-extended to 2*WI so the truncated product is exact.
  logic [N*WP-1:0] prod_d, prod_q;
  logic            vld1_q;
  logic [2:0]      flg1_q;   // {relu, last, first}

  always_comb begin
    prod_d = '0;
    for (int k = 0; k < N; k++) begin
      `MAC_LANE(prod_d, k, WP) = {{WI{w_q[(k+1)*WI-1]}}, `MAC_LANE(w_q, k, WI)}
                               * {{WI{d_q[(k+1)*WI-1]}}, `MAC_LANE(d_q, k, WI)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '0;
      vld1_q <= 1'b0;
      flg1_q <= '0;
    end else begin
      prod_q <= prod_d;
      vld1_q <= vld0_q;
      flg1_q <= {relu0_q, last0_q, first0_q};
    end
  end

  // S2..S(1+LOG2N): adder tree
  logic [WT-1:0] sum_t;
  logic          vld_t;
  logic [2:0]    flg_t;

  mac_adder_tree #(.N(N), .WIN(WP)) u_tree (
    .clk   (clk),
    .rst   (rst),
    .vld_i (vld1_q),
    .flg_i (flg1_q),
    .din   (prod_q),
    .sum_o (sum_t),
    .vld_o (vld_t),
    .flg_o (flg_t)
  );

  // SA: accumulator with burst-open flag
  logic [WACC-1:0] tree_ext;
  logic [WACC-1:0] acc_d, acc_q;
  logic            open_d, open_q;
  logic            fire_d, fire_q;
  logic            relu_d, relu_q;

  assign tree_ext = {{(WACC-WT){sum_t[WT-1]}}, sum_t};

  always_comb begin
    acc_d  = acc_q;
    open_d = open_q;
    fire_d = 1'b0;
    relu_d = relu_q;
    if (vld_t) begin
      if (flg_t[0]) begin
        acc_d  = tree_ext;
        open_d = !flg_t[1];
        fire_d = flg_t[1];
        relu_d = flg_t[2];
      end else if (open_q) begin
        // Stray beats outside a burst never reach this branch, so acc is untouched.
        acc_d = acc_q + tree_ext;
        if (flg_t[1]) begin
          open_d = 1'b0;
          fire_d = 1'b1;
          relu_d = flg_t[2];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      open_q <= 1'b0;
      fire_q <= 1'b0;
      relu_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      open_q <= open_d;
      fire_q <= fire_d;
      relu_q <= relu_d;
    end
  end

  // SQ: shift (floor), optional ReLU, signed saturation
  logic signed [WACC-1:0]   acc_s, t_sh;
  logic signed [CLIP_W-1:0] t_ext;
  logic [1:0]               ovr;
  logic [WO-1:0]            q_d;

  always_comb begin
    acc_s = acc_q;
    t_sh  = acc_s >>> SHIFT;
    if (relu_q && t_sh[WACC-1]) t_sh = '0;
    t_ext = CLIP_W'(t_sh);
    ovr   = sat_clip(t_ext, WO);
    if (ovr[1])      q_d = {1'b0, {(WO-1){1'b1}}};
    else if (ovr[0]) q_d = {1'b1, {(WO-1){1'b0}}};
    else             q_d = t_sh[WO-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_o <= '0;
      q_o   <= '0;
      sat_o <= 1'b0;
      vld_o <= 1'b0;
    end else begin
      vld_o <= fire_q;
      if (fire_q) begin
        acc_o <= acc_q;
        q_o   <= q_d;
        sat_o <= |ovr;
      end
    end
  end

endmodule

// File: tb/tb_mac_tree_acc.sv
// tb_mac_tree_acc: directed self-checking bench for mac_tree_acc (N=16, WI=8, WO=8).
// A second instance with SHIFT=14 shares the stimulus for the shifted-result case.

module tb_mac_tree_acc;

  localparam int WI   = 8;
  localparam int N    = 16;
  localparam int MB   = 64;
  localparam int WO   = 8;
  localparam int WACC = 2*WI + $clog2(N) + $clog2(MB) + 1;

  logic            clk = 1'b0;
  logic            rst, vld_i, first_i, last_i, relu_i;
  logic [N*WI-1:0] win, din;
  logic [WACC-1:0] acc_o, acc_s14;
  logic [WO-1:0]   q_o, q_s14;
  logic            sat_o, sat_s14, vld_o, vld_s14;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mac_tree_acc #(.WI(WI), .N(N), .MAX_BEATS(MB), .WO(WO), .SHIFT(0)) dut (
    .clk(clk), .rst(rst), .vld_i(vld_i), .first_i(first_i), .last_i(last_i),
    .relu_i(relu_i), .win(win), .din(din),
    .acc_o(acc_o), .q_o(q_o), .sat_o(sat_o), .vld_o(vld_o)
  );

  mac_tree_acc #(.WI(WI), .N(N), .MAX_BEATS(MB), .WO(WO), .SHIFT(14)) dut_s14 (
    .clk(clk), .rst(rst), .vld_i(vld_i), .first_i(first_i), .last_i(last_i),
    .relu_i(relu_i), .win(win), .din(din),
    .acc_o(acc_s14), .q_o(q_s14), .sat_o(sat_s14), .vld_o(vld_s14)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [N*WI-1:0] all_l(input int v);
    logic [WI-1:0] b;
    b = v[WI-1:0];
    return {N{b}};
  endfunction

  function automatic logic [N*WI-1:0] lane0(input int v);
    logic [N*WI-1:0] r;
    r = '0;
    r[WI-1:0] = v[WI-1:0];
    return r;
  endfunction

  function automatic longint sacc();
    return longint'($signed(acc_o));
  endfunction

  function automatic longint sq();
    return longint'($signed(q_o));
  endfunction

  task automatic beat(input logic f, input logic l, input logic r,
                      input logic [N*WI-1:0] w, input logic [N*WI-1:0] d);
    @(negedge clk);
    vld_i = 1'b1; first_i = f; last_i = l; relu_i = r; win = w; din = d;
  endtask

  task automatic idle();
    @(negedge clk);
    vld_i = 1'b0; first_i = 1'b0; last_i = 1'b0; relu_i = 1'b0; win = '0; din = '0;
  endtask

  task automatic wait_vld();
    int c;
    c = 0;
    while (!vld_o && c < 30) begin
      idle();
      c++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int early, pulses;
    longint got_acc;

    rst = 1'b1; vld_i = 1'b0; first_i = 1'b0; last_i = 1'b0; relu_i = 1'b0;
    win = '0; din = '0;
    repeat (3) @(negedge clk);
    chk("rst_acc", sacc(), 0);
    chk("rst_q", sq(), 0);
    chk("rst_sat", sat_o, 0);
    chk("rst_vld", vld_o, 0);
    rst = 1'b0;
    repeat (2) idle();

    // 1: single-beat burst, 16 x (3 * -2) = -96, exact latency 8
    beat(1, 1, 0, all_l(3), all_l(-2));
    early = 0;
    for (int c = 1; c < 8; c++) begin
      idle();
      early += int'(vld_o);
    end
    idle();
    chk("t1_early", early, 0);
    chk("t1_vld", vld_o, 1);
    chk("t1_acc", sacc(), -96);
    chk("t1_q", sq(), -96);
    chk("t1_sat", sat_o, 0);
    idle();
    chk("t1_single", vld_o, 0);

    // 2: 4 beats of 16 x (-128 * -128) = 1048576; saturates unshifted, 64 with SHIFT=14
    beat(1, 0, 0, all_l(-128), all_l(-128));
    beat(0, 0, 0, all_l(-128), all_l(-128));
    beat(0, 0, 0, all_l(-128), all_l(-128));
    beat(0, 1, 0, all_l(-128), all_l(-128));
    wait_vld();
    chk("t2_vld", vld_o, 1);
    chk("t2_acc", sacc(), 1048576);
    chk("t2_q", sq(), 127);
    chk("t2_sat", sat_o, 1);
    chk("t2_s14_vld", vld_s14, 1);
    chk("t2_s14_acc", longint'($signed(acc_s14)), 1048576);
    chk("t2_s14_q", longint'($signed(q_s14)), 64);
    chk("t2_s14_sat", sat_s14, 0);

    // 3: back-to-back 1-beat bursts, lane0 1*i, results 0..9 with no bubbles
    for (int i = 0; i < 18; i++) begin
      if (i < 10) beat(1, 1, 0, lane0(1), lane0(i));
      else        idle();
      if (i >= 8) begin
        chk("t3_vld", vld_o, 1);
        chk("t3_q", sq(), i - 8);
      end
    end
    idle();
    chk("t3_end", vld_o, 0);

    // 4: ReLU on a -20 sum, then without ReLU, then negative saturation (-200)
    beat(1, 1, 1, lane0(4), lane0(-5));
    wait_vld();
    chk("t4_relu_acc", sacc(), -20);
    chk("t4_relu_q", sq(), 0);
    chk("t4_relu_sat", sat_o, 0);
    beat(1, 1, 0, lane0(4), lane0(-5));
    wait_vld();
    chk("t4_norelu_q", sq(), -20);
    beat(1, 1, 0, lane0(-100), lane0(2));
    wait_vld();
    chk("t4_neg_acc", sacc(), -200);
    chk("t4_neg_q", sq(), -128);
    chk("t4_neg_sat", sat_o, 1);

    // 5: reset during beat 2 of a burst, then a fresh 2-beat burst 2*3 + 5*1 = 11
    beat(1, 0, 0, lane0(9), lane0(9));
    beat(0, 0, 0, lane0(9), lane0(9));
    rst = 1'b1;
    idle();
    rst = 1'b0;
    chk("t5_rst_acc", sacc(), 0);
    chk("t5_rst_q", sq(), 0);
    chk("t5_rst_sat", sat_o, 0);
    beat(1, 0, 0, lane0(2), lane0(3));
    beat(0, 1, 0, lane0(5), lane0(1));
    pulses = 0;
    got_acc = 0;
    for (int c = 0; c < 14; c++) begin
      idle();
      if (vld_o) begin
        pulses++;
        got_acc = sacc();
      end
    end
    chk("t5_pulses", pulses, 1);
    chk("t5_acc", got_acc, 11);

    // 6: stray beats outside a burst, then a restart mid-burst: 3 + 4 + 5 = 12
    beat(0, 0, 0, lane0(50), lane0(2));
    beat(0, 1, 0, lane0(50), lane0(2));
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      idle();
      pulses += int'(vld_o);
    end
    chk("t6_stray_pulses", pulses, 0);
    chk("t6_hold_acc", sacc(), 11);
    beat(1, 0, 0, lane0(7), lane0(1));
    beat(0, 0, 0, lane0(10), lane0(1));
    beat(1, 0, 0, lane0(3), lane0(1));
    beat(0, 0, 0, lane0(4), lane0(1));
    beat(0, 1, 0, lane0(5), lane0(1));
    wait_vld();
    chk("t6_vld", vld_o, 1);
    chk("t6_acc", sacc(), 12);
    chk("t6_q", sq(), 12);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
